// File: rtl/ic_pkg.sv
// Shared types and helpers for the prio_interrupt_ctrl codebase: FSM encoding,
// default vector layout and the channel-to-vector address function.
package ic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } ic_state_e;

  localparam logic [15:0] IC_VEC_BASE   = 16'hFFC0;
  localparam int          IC_VEC_STRIDE = 4;

  // Computed at 32 bits; callers truncate to their address width, giving the wrap.
  function automatic logic [31:0] ic_vector(input logic [31:0] base,
                                            input logic [31:0] stride,
                                            input logic [31:0] ch);
    return base + (ch * stride);
  endfunction

endpackage

// File: rtl/prio_interrupt_ctrl_if.sv
// CPU-side request/acknowledge channel of the interrupt controller.
// master = controller, slave = CPU control unit.
interface prio_interrupt_ctrl_if #(
  parameter int NUM_CH = 8,
  parameter int PRI_W  = 3,
  parameter int ADDR_W = 16
);
  logic                      int_req;
  logic                      int_ack;
  logic                      int_done;
  logic [ADDR_W-1:0]         int_vec;
  logic [$clog2(NUM_CH)-1:0] int_ch;
  logic [PRI_W-1:0]          int_pri;
  logic                      in_service;

  modport master (
    output int_req, int_vec, int_ch, int_pri, in_service,
    input  int_ack, int_done
  );

  modport slave (
    input  int_req, int_vec, int_ch, int_pri, in_service,
    output int_ack, int_done
  );
endinterface

// File: rtl/ic_arbiter.sv
// Combinational priority arbiter: highest priority among candidates wins,
// ties resolved towards the lowest channel index.
module ic_arbiter
  import ic_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int PRI_W  = 3
) (
  input  logic [NUM_CH-1:0]         cand_i,
  input  logic [NUM_CH*PRI_W-1:0]   pri_i,
  output logic                      valid_o,
  output logic [$clog2(NUM_CH)-1:0] idx_o,
  output logic [PRI_W-1:0]          pri_o
);
  localparam int IDX_W = $clog2(NUM_CH);

  logic                 valid_s;
  logic [IDX_W-1:0]     idx_s;
  logic [PRI_W-1:0]     pri_s;
  logic                 take_s;

  // Scan upwards; a strict compare keeps the earlier (lower) index on ties.
  always_comb begin
    valid_s = 1'b0;
    idx_s   = '0;
    pri_s   = '0;
    take_s  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      take_s  = cand_i[i] & (~valid_s | (pri_i[i*PRI_W +: PRI_W] > pri_s));
      idx_s   = take_s ? IDX_W'(i) : idx_s;
      pri_s   = take_s ? pri_i[i*PRI_W +: PRI_W] : pri_s;
      valid_s = valid_s | take_s;
    end
  end

  assign valid_o = valid_s;
  assign idx_o   = idx_s;
  assign pri_o   = pri_s;

endmodule

// File: rtl/prio_interrupt_ctrl.sv
// Vectored priority interrupt controller. Define IC_NESTING_EN to enable
// nested servicing through an in-service stack of depth 2**PRI_W.
module prio_interrupt_ctrl
  import ic_pkg::*;
#(
  parameter int                NUM_CH     = 8,
  parameter int                PRI_W      = 3,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(IC_VEC_BASE),
  parameter int                VEC_STRIDE = IC_VEC_STRIDE
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         irq_in,
  input  logic                      psw_ie,
  input  logic [PRI_W-1:0]          cpu_pri,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic                      cfg_en,
  input  logic [PRI_W-1:0]          cfg_pri,
  prio_interrupt_ctrl_if.master     cpu
);
  localparam int IDX_W = $clog2(NUM_CH);

  ic_state_e                state_q, state_d;
  logic [NUM_CH-1:0]        irq_q, pend_q, pend_d, en_q;
  logic [NUM_CH*PRI_W-1:0]  pri_q;
  logic                     int_req_q, int_req_d;
  logic [ADDR_W-1:0]        vec_q, vec_d;
  logic [IDX_W-1:0]         ch_q, ch_d;
  logic [PRI_W-1:0]         ipri_q, ipri_d;
  logic                     insvc_q, insvc_d;

  logic                     win_valid_s;
  logic [IDX_W-1:0]         win_ch_s;
  logic [PRI_W-1:0]         win_pri_s;
  logic                     eligible_s, grant_s, ack_s, done_s, withdraw_s;
  logic                     back_svc_s, done_svc_s;
  logic [NUM_CH-1:0]        set_s, clr_s;

  ic_arbiter #(.NUM_CH(NUM_CH), .PRI_W(PRI_W)) u_arb (
    .cand_i  (pend_q & en_q),
    .pri_i   (pri_q),
    .valid_o (win_valid_s),
    .idx_o   (win_ch_s),
    .pri_o   (win_pri_s)
  );

  assign eligible_s = win_valid_s & psw_ie & (win_pri_s > cpu_pri);
  assign ack_s      = (state_q == REQ) & cpu.int_ack;
  assign done_s     = (state_q == SERVICE) & cpu.int_done;
  assign withdraw_s = (state_q == REQ) & ~cpu.int_ack & ~psw_ie;

`ifdef IC_NESTING_EN
  localparam int DEPTH = 2**PRI_W;

  logic [IDX_W-1:0]  stk_ch_q  [DEPTH];
  logic [PRI_W-1:0]  stk_pri_q [DEPTH];
  logic [PRI_W:0]    sp_q, sp_d;
  logic [PRI_W-1:0]  top_idx_s, under_idx_s, top_pri_s;

  assign top_idx_s   = PRI_W'(sp_q - (PRI_W+1)'(1));
  assign under_idx_s = PRI_W'(sp_q - (PRI_W+1)'(2));
  assign top_pri_s   = (sp_q != '0) ? stk_pri_q[top_idx_s] : '0;
  // A nested request must beat whatever is currently on top of the stack.
  assign grant_s     = ((state_q == IDLE) & eligible_s) |
                       ((state_q == SERVICE) & ~cpu.int_done & eligible_s &
                        (win_pri_s > top_pri_s));
  assign back_svc_s  = (sp_q != '0);
  assign done_svc_s  = (sp_q > (PRI_W+1)'(1));
  assign sp_d        = sp_q + {{PRI_W{1'b0}}, ack_s} - {{PRI_W{1'b0}}, done_s};

  // In-service stack: ack pushes the granted {ch, pri}, done pops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_ch_q[i]  <= '0;
        stk_pri_q[i] <= '0;
      end
    end else begin
      sp_q <= sp_d;
      if (ack_s) begin
        stk_ch_q[sp_q[PRI_W-1:0]]  <= ch_q;
        stk_pri_q[sp_q[PRI_W-1:0]] <= ipri_q;
      end
    end
  end

  stack_no_overflow_a: assert property (@(posedge clock) disable iff (!reset_n)
    ack_s |-> (sp_q != (PRI_W+1)'(DEPTH)));
`else
  assign grant_s    = (state_q == IDLE) & eligible_s;
  assign back_svc_s = 1'b0;
  assign done_svc_s = 1'b0;
`endif

  // Pending latch: rising edge on an enabled line sets; ack or disable clears; set wins.
  always_comb begin
    set_s  = irq_in & ~irq_q & en_q;
    clr_s  = (ack_s ? (NUM_CH'(1'b1) << ch_q) : '0) |
             ((cfg_we & ~cfg_en) ? (NUM_CH'(1'b1) << cfg_ch) : '0);
    pend_d = (pend_q & ~clr_s) | set_s;
  end

  // Edge history, pending bits and per-channel configuration.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_q  <= '0;
      pend_q <= '0;
      en_q   <= '0;
      pri_q  <= '0;
    end else begin
      irq_q  <= irq_in;
      pend_q <= pend_d;
      if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
        en_q[cfg_ch]                  <= cfg_en;
        pri_q[cfg_ch*PRI_W +: PRI_W]  <= cfg_pri;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = grant_s ? REQ : IDLE;
      REQ:     state_d = ack_s ? SERVICE :
                         withdraw_s ? (back_svc_s ? SERVICE : IDLE) : REQ;
      SERVICE: state_d = done_s ? (done_svc_s ? SERVICE : IDLE) :
                         grant_s ? REQ : SERVICE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request level, latched payload and in-service flag.
  always_comb begin
    int_req_d = grant_s | (int_req_q & ~ack_s & ~withdraw_s);
    vec_d     = vec_q;
    ch_d      = ch_q;
    ipri_d    = ipri_q;
    if (grant_s) begin
      vec_d  = ADDR_W'(ic_vector(32'(VEC_BASE), 32'(VEC_STRIDE), 32'(win_ch_s)));
      ch_d   = win_ch_s;
      ipri_d = win_pri_s;
`ifdef IC_NESTING_EN
    end else if (withdraw_s && back_svc_s) begin
      ch_d   = stk_ch_q[top_idx_s];
      ipri_d = stk_pri_q[top_idx_s];
    end else if (done_s && done_svc_s) begin
      ch_d   = stk_ch_q[under_idx_s];
      ipri_d = stk_pri_q[under_idx_s];
`endif
    end else begin
      vec_d  = vec_q;
    end
`ifdef IC_NESTING_EN
    insvc_d = (sp_d != '0);
`else
    insvc_d = ack_s | (insvc_q & ~done_s);
`endif
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      int_req_q <= 1'b0;
      vec_q     <= '0;
      ch_q      <= '0;
      ipri_q    <= '0;
      insvc_q   <= 1'b0;
    end else begin
      int_req_q <= int_req_d;
      vec_q     <= vec_d;
      ch_q      <= ch_d;
      ipri_q    <= ipri_d;
      insvc_q   <= insvc_d;
    end
  end

  assign cpu.int_req    = int_req_q;
  assign cpu.int_vec    = vec_q;
  assign cpu.int_ch     = ch_q;
  assign cpu.int_pri    = ipri_q;
  assign cpu.in_service = insvc_q;

endmodule

// File: tb/tb_prio_interrupt_ctrl.sv
// Scoreboard bench for prio_interrupt_ctrl: directed scenarios then random traffic
// against a behavioural model; follows IC_NESTING_EN when defined.
module tb_prio_interrupt_ctrl;
  localparam int NUM_CH = 8;

  typedef struct { int ch; int pri; } ent_t;
  typedef struct { logic [15:0] vec; int ch; int pri; } grant_t;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irq_in  = '0;
  logic       psw_ie  = 1'b0;
  logic [2:0] cpu_pri = '0;
  logic       cfg_we  = 1'b0;
  logic [2:0] cfg_ch  = '0;
  logic       cfg_en  = 1'b0;
  logic [2:0] cfg_pri = '0;

  int nvec  = 0;
  int nfail = 0;

  prio_interrupt_ctrl_if #(.NUM_CH(8), .PRI_W(3), .ADDR_W(16)) cpu_if ();

  prio_interrupt_ctrl dut (
    .clock   (clock),
    .reset_n (reset_n),
    .irq_in  (irq_in),
    .psw_ie  (psw_ie),
    .cpu_pri (cpu_pri),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_en  (cfg_en),
    .cfg_pri (cfg_pri),
    .cpu     (cpu_if)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] vec_of(input int ch);
    return 16'(32'hFFC0 + ch * 4);
  endfunction

  // ---------------- behavioural reference model ----------------
  bit     pend_m [NUM_CH];
  bit     en_m   [NUM_CH];
  bit     last_m [NUM_CH];
  int     pri_m  [NUM_CH];
  bit     req_m;
  int     rch_m, rpri_m;
  ent_t   stack_m [$];
  grant_t exp_q   [$];

  always @(posedge clock or negedge reset_n) begin : model
    int  best, bpri;
    bit  elig;
    bit  npend [NUM_CH];
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pend_m[i] = 0; en_m[i] = 0; last_m[i] = 0; pri_m[i] = 0;
      end
      req_m = 0;
      stack_m.delete();
      exp_q.delete();
    end else begin
      best = -1;
      bpri = -1;
      for (int i = 0; i < NUM_CH; i++)
        if (pend_m[i] && en_m[i] && pri_m[i] > bpri) begin best = i; bpri = pri_m[i]; end
      elig = (best >= 0) && psw_ie && (bpri > int'(cpu_pri));
      for (int i = 0; i < NUM_CH; i++)
        npend[i] = (irq_in[i] && !last_m[i] && en_m[i]) ||
                   (pend_m[i] && !((req_m && cpu_if.int_ack && i == rch_m) ||
                                   (cfg_we && !cfg_en && i == int'(cfg_ch))));
      if (req_m) begin
        if (cpu_if.int_ack) begin
          req_m = 0;
          stack_m.push_back('{rch_m, rpri_m});
        end else if (!psw_ie) begin
          req_m = 0;
        end
      end else if (stack_m.size() > 0) begin
        if (cpu_if.int_done) void'(stack_m.pop_back());
`ifdef IC_NESTING_EN
        else if (elig && bpri > stack_m[$].pri) begin
          req_m = 1; rch_m = best; rpri_m = bpri;
          exp_q.push_back('{vec_of(best), best, bpri});
        end
`endif
      end else if (elig) begin
        req_m = 1; rch_m = best; rpri_m = bpri;
        exp_q.push_back('{vec_of(best), best, bpri});
      end
      for (int i = 0; i < NUM_CH; i++) begin
        pend_m[i] = npend[i];
        last_m[i] = irq_in[i];
      end
      if (cfg_we) begin
        en_m[cfg_ch]  = cfg_en;
        pri_m[cfg_ch] = int'(cfg_pri);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit prev_req = 0;
  always @(negedge clock) begin : monitor
    grant_t g;
    if (!reset_n) begin
      prev_req = 0;
    end else begin
      check("int_req", cpu_if.int_req, req_m);
      check("in_service", cpu_if.in_service, stack_m.size() > 0);
      if (!req_m && stack_m.size() > 0) begin
        check("svc_ch", cpu_if.int_ch, stack_m[$].ch);
        check("svc_pri", cpu_if.int_pri, stack_m[$].pri);
      end
      if (cpu_if.int_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL grant_unexpected: int_req rose for ch %0d, none expected", cpu_if.int_ch);
        end else begin
          g = exp_q.pop_front();
          check("grant_vec", cpu_if.int_vec, g.vec);
          check("grant_ch", cpu_if.int_ch, g.ch);
          check("grant_pri", cpu_if.int_pri, g.pri);
        end
      end
      prev_req = cpu_if.int_req;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic cfg(input int ch, input bit en, input int pri);
    cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_en = en; cfg_pri = 3'(pri);
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic wait_req(input string name, input int max);
    int k = 0;
    while (!cpu_if.int_req && k < max) begin tick(1); k++; end
    check(name, cpu_if.int_req, 1'b1);
  endtask

  task automatic ack_done();
    cpu_if.int_ack = 1'b1; tick(1); cpu_if.int_ack = 1'b0;
    check("ack_in_service", cpu_if.in_service, 1'b1);
    cpu_if.int_done = 1'b1; tick(1); cpu_if.int_done = 1'b0;
    check("done_in_service", cpu_if.in_service, 1'b0);
  endtask

  initial begin
    cpu_if.int_ack  = 1'b0;
    cpu_if.int_done = 1'b0;
    tick(3);
    check("rst_int_req", cpu_if.int_req, 1'b0);
    check("rst_int_vec", cpu_if.int_vec, 16'h0000);
    check("rst_int_ch", cpu_if.int_ch, 3'd0);
    check("rst_int_pri", cpu_if.int_pri, 3'd0);
    check("rst_in_service", cpu_if.in_service, 1'b0);
    reset_n = 1'b1;
    psw_ie  = 1'b1;
    cpu_pri = 3'd2;
    tick(1);

    // single channel, two-cycle latency
    cfg(3, 1'b1, 5);
    irq_in[3] = 1'b1;
    tick(1);
    check("lat_cycle1_req", cpu_if.int_req, 1'b0);
    tick(1);
    check("lat_cycle2_req", cpu_if.int_req, 1'b1);
    check("ch3_vec", cpu_if.int_vec, 16'hFFCC);
    check("ch3_ch", cpu_if.int_ch, 3'd3);
    check("ch3_pri", cpu_if.int_pri, 3'd5);
    ack_done();

    // equal priority tie -> lowest index first
    irq_in = '0; tick(1);
    cfg(1, 1'b1, 4);
    cfg(6, 1'b1, 4);
    irq_in[1] = 1'b1; irq_in[6] = 1'b1;
    tick(2);
    check("tie_req", cpu_if.int_req, 1'b1);
    check("tie_vec", cpu_if.int_vec, 16'hFFC4);
    ack_done();
    wait_req("ch6_req", 4);
    check("ch6_vec", cpu_if.int_vec, 16'hFFD8);
    ack_done();

    // equal to cpu_pri never interrupts; lowering cpu_pri does
    irq_in = '0; tick(1);
    cpu_pri = 3'd3;
    cfg(2, 1'b1, 3);
    irq_in[2] = 1'b1;
    tick(5);
    check("equal_pri_no_req", cpu_if.int_req, 1'b0);
    cpu_pri = 3'd2;
    wait_req("lower_cpu_pri_req", 2);

    // psw_ie withdrawal keeps the pending request
    psw_ie = 1'b0;
    tick(1);
    check("withdraw_req", cpu_if.int_req, 1'b0);
    psw_ie = 1'b1;
    wait_req("reissue_req", 3);
    check("reissue_ch", cpu_if.int_ch, 3'd2);
    ack_done();

    // higher priority arrives while in service
    irq_in = '0; tick(1);
    cpu_pri = 3'd1;
    cfg(0, 1'b1, 2);
    cfg(5, 1'b1, 7);
    irq_in[0] = 1'b1;
    wait_req("ch0_req", 4);
    check("ch0_ch", cpu_if.int_ch, 3'd0);
    cpu_if.int_ack = 1'b1; tick(1); cpu_if.int_ack = 1'b0;
    irq_in[5] = 1'b1;
    tick(4);
`ifdef IC_NESTING_EN
    check("nest_req", cpu_if.int_req, 1'b1);
    check("nest_ch", cpu_if.int_ch, 3'd5);
    cpu_if.int_ack = 1'b1; tick(1); cpu_if.int_ack = 1'b0;
    check("nest_pri", cpu_if.int_pri, 3'd7);
    cpu_if.int_done = 1'b1; tick(1); cpu_if.int_done = 1'b0;
    check("unnest_pri", cpu_if.int_pri, 3'd2);
    check("unnest_in_service", cpu_if.in_service, 1'b1);
    cpu_if.int_done = 1'b1; tick(1); cpu_if.int_done = 1'b0;
    check("final_in_service", cpu_if.in_service, 1'b0);
`else
    check("no_nest_req", cpu_if.int_req, 1'b0);
    cpu_if.int_done = 1'b1; tick(1); cpu_if.int_done = 1'b0;
    check("ch0_done", cpu_if.in_service, 1'b0);
    wait_req("ch5_after_done", 4);
    check("ch5_ch", cpu_if.int_ch, 3'd5);
    ack_done();
`endif

    // asynchronous reset in the middle of a request
    irq_in = '0; tick(1);
    cfg(4, 1'b1, 6);
    irq_in[4] = 1'b1;
    wait_req("ch4_req", 4);
    #2 reset_n = 1'b0;
    #1 check("async_reset_req", cpu_if.int_req, 1'b0);
    check("async_reset_in_service", cpu_if.in_service, 1'b0);
    @(negedge clock) reset_n = 1'b1;
    tick(5);
    check("no_req_after_reset", cpu_if.int_req, 1'b0);

    // random traffic
    irq_in = '0;
    for (int c = 0; c < NUM_CH; c++) cfg(c, 1'b1, $urandom_range(0, 7));
    for (int n = 0; n < 3000; n++) begin
      irq_in  = irq_in ^ 8'($urandom & $urandom & $urandom);
      psw_ie  = ($urandom % 16) != 0;
      if (($urandom % 8) == 0) cpu_pri = 3'($urandom_range(0, 5));
      cfg_we  = ($urandom % 16) == 0;
      cfg_ch  = 3'($urandom);
      cfg_en  = ($urandom % 4) != 0;
      cfg_pri = 3'($urandom);
      cpu_if.int_ack  = cpu_if.int_req ? (($urandom % 3) == 0) : (($urandom % 20) == 0);
      cpu_if.int_done = cpu_if.in_service ? (($urandom % 4) == 0) : (($urandom % 20) == 0);
      tick(1);
    end
    cfg_we = 1'b0; psw_ie = 1'b0; cpu_if.int_ack = 1'b0;
    for (int n = 0; n < 24; n++) begin
      cpu_if.int_done = cpu_if.in_service;
      tick(1);
    end
    cpu_if.int_done = 1'b0;
    tick(2);
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_idle_in_service", cpu_if.in_service, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
